// File: rtl/pes_pipe_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 captures operands plus bit/block propagate-generate; stage 2 resolves carries and flags.
module pes_pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF,
    output logic             PG,
    output logic             GG
);
    localparam int NBLK = WIDTH / BLK;

    logic [WIDTH-1:0] be;
    logic             c0;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NBLK-1:0]  blk_pg;
    logic [NBLK-1:0]  blk_gg;

    logic             s1_valid;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] be_r;
    logic             c0_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic [NBLK-1:0]  bpg_r;
    logic [NBLK-1:0]  bgg_r;

    logic [NBLK:0]    blk_c;
    logic             word_gg;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;

    logic             s2_valid;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             pg_q;
    logic             gg_q;

    logic             s2_adv;
    logic             accept;

    assign be     = SUB ? ~B : B;
    assign c0     = SUB ? 1'b1 : Cin;
    assign p      = A ^ be;
    assign g      = A & be;

    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    always_comb begin : block_lookahead
        logic pg_acc;
        logic gg_acc;
        logic term;
        blk_pg = '0;
        blk_gg = '0;
        for (int j = 0; j < NBLK; j++) begin
            pg_acc = 1'b1;
            gg_acc = 1'b0;
            for (int k = 0; k < BLK; k++) begin
                pg_acc = pg_acc & p[j*BLK+k];
                term   = g[j*BLK+k];
                for (int m = k + 1; m < BLK; m++) begin
                    term = term & p[j*BLK+m];
                end
                gg_acc = gg_acc | term;
            end
            blk_pg[j] = pg_acc;
            blk_gg[j] = gg_acc;
        end
    end

    // Each block carry is a flat sum of products over lower blocks' PG/GG, not a chain.
    always_comb begin : block_carries
        logic acc;
        logic term;
        blk_c = '0;
        for (int j = 0; j <= NBLK; j++) begin
            acc = c0_r;
            for (int m = 0; m < j; m++) begin
                acc = acc & bpg_r[m];
            end
            for (int k = 0; k < j; k++) begin
                term = bgg_r[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & bpg_r[m];
                end
                acc = acc | term;
            end
            blk_c[j] = acc;
        end
        acc = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            term = bgg_r[k];
            for (int m = k + 1; m < NBLK; m++) begin
                term = term & bpg_r[m];
            end
            acc = acc | term;
        end
        word_gg = acc;
    end

    always_comb begin : bit_carries
        logic acc;
        logic term;
        int   base;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            base = (i / BLK) * BLK;
            acc  = blk_c[i/BLK];
            for (int m = base; m < i; m++) begin
                acc = acc & p_r[m];
            end
            for (int k = base; k < i; k++) begin
                term = g_r[k];
                for (int m = k + 1; m < i; m++) begin
                    term = term & p_r[m];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
        c[WIDTH] = blk_c[NBLK];
    end

    assign sum_d = a_r ^ be_r ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            a_r      <= '0;
            be_r     <= '0;
            c0_r     <= 1'b0;
            p_r      <= '0;
            g_r      <= '0;
            bpg_r    <= '0;
            bgg_r    <= '0;
            s2_valid <= 1'b0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            pg_q     <= 1'b0;
            gg_q     <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                a_r   <= A;
                be_r  <= be;
                c0_r  <= c0;
                p_r   <= p;
                g_r   <= g;
                bpg_r <= blk_pg;
                bgg_r <= blk_gg;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                s_q    <= sum_d;
                cout_q <= c[WIDTH];
                ovf_q  <= c[WIDTH-1] ^ c[WIDTH];
                pg_q   <= &bpg_r;
                gg_q   <= word_gg;
            end
        end
    end

    assign out_valid = s2_valid;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign OVF       = ovf_q;
    assign PG        = pg_q;
    assign GG        = gg_q;
endmodule

// File: tb/tb_pes_pipe_cla_adder.sv
// Self-checking bench: directed corner cases, backpressure, reset flush and random streaming
// against an arithmetic reference model with an in-order scoreboard.
module tb_pes_pipe_cla_adder;
    localparam int WIDTH = 16;
    localparam int RW    = WIDTH + 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;
    logic             PG;
    logic             GG;

    int nVectors;
    int nMiscompares;

    logic [RW-1:0] sbQ[$];
    logic          prevRst;
    logic          prevStall;
    logic [RW-1:0] held;
    logic [RW-1:0] outs;
    logic          bgDone;

    pes_pipe_cla_adder #(.WIDTH(WIDTH), .BLK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .SUB       (SUB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .OVF       (OVF),
        .PG        (PG),
        .GG        (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outs = {S, Cout, OVF, PG, GG};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic; GG is the carry out with no carry-in.
    function automatic logic [RW-1:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        logic [WIDTH-1:0] bEff;
        logic             c0;
        logic [WIDTH:0]   full;
        logic [WIDTH:0]   gen;
        logic             ovf;
        logic             pg;
        bEff = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, c0};
        gen  = {1'b0, a} + {1'b0, bEff};
        ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        pg   = ((a ^ bEff) == {WIDTH{1'b1}});
        return {full[WIDTH-1:0], full[WIDTH], ovf, pg, gen[WIDTH]};
    endfunction

    // Monitor at the falling edge: transfers seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("in_ready_in_rst", {63'd0, in_ready}, 64'd0);
            sbQ.delete();
        end
        if (prevRst) begin
            checkOutput("rst_out", {43'd0, out_valid, outs}, 64'd0);
            if (!rst) checkOutput("ready_after_rst", {63'd0, in_ready}, 64'd1);
        end else if (prevStall) begin
            checkOutput("hold", {43'd0, out_valid, outs}, {43'd0, 1'b1, held});
        end
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) checkOutput("unexpected_out", {44'd0, outs}, 64'hDEAD);
                else checkOutput("result", {44'd0, outs}, {44'd0, sbQ.pop_front()});
            end
            if (in_valid && in_ready) sbQ.push_back(refModel(A, B, Cin, SUB));
        end
        prevRst   = rst;
        prevStall = !rst && out_valid && !out_ready;
        held      = outs;
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, output int waits);
        logic acc;
        acc      = 1'b0;
        waits    = 0;
        A        = a;
        B        = b;
        Cin      = cin;
        SUB      = sub;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
        end
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        A        = WIDTH'($urandom);
        B        = WIDTH'($urandom);
        Cin      = 1'($urandom);
        SUB      = 1'($urandom);
    endtask

    task automatic randomOp(output int waits);
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), waits);
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic [RW-1:0] exp);
        int waits;
        out_ready = 1'b1;
        applyStimulus(a, b, cin, sub, waits);
        stepCycles(1);
        checkOutput(tag, {43'd0, out_valid, outs}, {43'd0, 1'b1, exp});
    endtask

    initial begin
        int waits;
        nVectors     = 0;
        nMiscompares = 0;
        prevRst      = 1'b1;
        prevStall    = 1'b0;
        held         = '0;
        bgDone       = 1'b0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        A            = '0;
        B            = '0;
        Cin          = 1'b0;
        SUB          = 1'b0;
        stepCycles(3);
        rst = 1'b0;
        stepCycles(1);

        directed("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000});
        directed("full_prop", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b1010});
        directed("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 4'b0000});
        directed("sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 4'b0000});
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1101});
        stepCycles(3);

        // Backpressure: two accepts fill the pipe, the third must wait.
        out_ready = 1'b0;
        randomOp(waits);
        randomOp(waits);
        checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        A        = 16'h1234;
        B        = 16'h4321;
        Cin      = 1'b1;
        SUB      = 1'b0;
        in_valid = 1'b1;
        stepCycles(3);
        checkOutput("bp_still_full", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, waits);
        randomOp(waits);
        stepCycles(4);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        randomOp(waits);
        randomOp(waits);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("rst_flush_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        stepCycles(5);

        for (int i = 0; i < 100; i++) begin
            randomOp(waits);
            checkOutput("stream_wait", waits, 64'd0);
        end

        fork
            begin
                for (int i = 0; i < 100; i++) randomOp(waits);
                bgDone = 1'b1;
            end
            begin
                while (!bgDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        for (int i = 0; i < 50 && sbQ.size() != 0; i++) stepCycles(1);
        stepCycles(2);
        checkOutput("drain", sbQ.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule

// File: doc/pes_pipe_cla_adder.md
PES_PIPE_CLA_ADDER -- requirements
Module: pes_pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits; multiple of 4; legal range 4..64.
REQ-002 SHALL have parameter BLK, fixed at 4: lookahead block width; the design SHALL use NBLK = WIDTH/4 blocks.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-007 SHALL have port A, input, WIDTH bits: operand A.
REQ-008 SHALL have port B, input, WIDTH bits: operand B.
REQ-009 SHALL have port Cin, input, 1 bit: carry-in; ignored when SUB=1.
REQ-010 SHALL have port SUB, input, 1 bit: 0 = A+B+Cin; 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port S, output, WIDTH bits: sum/difference.
REQ-014 SHALL have port Cout, output, 1 bit: carry out of MSB; for SUB=1, 1 = no borrow.
REQ-015 SHALL have port OVF, output, 1 bit: two's-complement signed overflow.
REQ-016 SHALL have port PG, output, 1 bit: whole-word group propagate.
REQ-017 SHALL have port GG, output, 1 bit: whole-word group generate.

Function
REQ-018 SHALL form effective operand Be = SUB ? ~B : B and carry-in C0 = SUB ? 1 : Cin at capture.
REQ-019 SHALL compute per-bit G = A & Be and P = A ^ Be.
REQ-020 SHALL compute per-block group propagate (AND of the block's 4 P bits) and group generate (4-bit lookahead).
REQ-021 SHALL compute block carries by a second-level lookahead over the block PG/GG, never a bit-serial ripple.
REQ-022 SHALL produce S = P ^ C, with Cout = the carry out of bit WIDTH-1.
REQ-023 SHALL produce OVF = carry into bit WIDTH-1 XOR Cout.
REQ-024 SHALL produce PG = AND of all P bits, and GG = whole-word generate independent of C0.
REQ-025 SHALL be a 2-stage pipeline:
- Stage 1 registers A, Be, C0, the per-bit P/G and the block PG/GG.
- Stage 2 registers S, Cout, OVF, PG and GG.
REQ-026 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when no backpressure is applied.
REQ-027 SHALL treat a transfer as occurring when valid and ready are both high on a rising edge, on each side.
REQ-028 SHALL load stage 2 when stage 2 is empty or out_ready=1 (s2_adv).
REQ-029 SHALL set in_ready = !s1_valid || s2_adv, combinationally.
REQ-030 SHALL sustain full throughput of 1 result per cycle while out_ready=1.
REQ-031 SHALL hold S, Cout, OVF, PG, GG and out_valid stable while out_valid=1 and out_ready=0.
REQ-032 SHALL neither drop nor duplicate any transaction under any in_valid/out_ready pattern, and SHALL deliver results in acceptance order.
REQ-033 SHALL ignore A, B, Cin and SUB when in_valid=0 or in_ready=0.
REQ-034 SHALL, when accept and output transfer occur in the same cycle, advance both stages.
REQ-035 SHALL wrap arithmetic modulo 2^WIDTH; the carry is reported only via Cout.

Reset
REQ-036 SHALL, while rst=1, clear both stage valid flags, leave out_valid=0, and hold S, Cout, OVF, PG and GG at 0.
REQ-037 SHALL discard all in-flight transactions when rst asserts mid-operation.
REQ-038 SHALL hold in_ready=0 during the rst=1 cycles.
REQ-039 SHALL have in_ready=1 on the first cycle after rst deasserts.

Verification (WIDTH=16)
REQ-040 Add: A=0x00FF, B=0x0001, Cin=0, SUB=0, out_ready=1 -> 2 cycles later S=0x0100, Cout=0, OVF=0, PG=0, GG=0.
REQ-041 Full propagate: A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1, PG=1, GG=0.
REQ-042 Subtract:
- A=0x0005, B=0x0007, SUB=1 -> S=0xFFFE, Cout=0, OVF=0.
- A=0x8000, B=0x0001, SUB=1 -> S=0x7FFF, Cout=1, OVF=1.
REQ-043 Backpressure: 4 back-to-back inputs with out_ready=0 -> in_ready=0 after 2 accepts; then out_ready=1 -> all 4 results in order, and the first result is held unchanged while stalled.
REQ-044 Streaming: 100 random operand sets, random SUB, out_ready=1 -> one result per cycle, each matching the reference sum/flags.
REQ-045 Reset mid-flight: 2 transactions in the pipe, rst=1 for 1 cycle -> out_valid=0 and outputs 0 next cycle, no stale result emitted, in_ready=1 after release.
